// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO fed by single-cycle strobes, 8N1 serializer, LSB first.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_fifo_full,
    output logic       o_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              baud_done;

    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;

`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign fifo_rd_data = fifo_mem[rd_ptr_q];
    assign fifo_empty   = (count_q == '0);
    assign baud_done    = (baud_q == '0);

    // FIFO bookkeeping; a push into a full FIFO is still taken when the FSM pops that cycle.
    always_comb begin
        push     = i_data_en && ((count_q != CNT_FULL) || pop);
        ovf_d    = i_data_en && !push;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_LOAD;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next frame so queued bytes go out with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        baud_d  = BAUD_LOAD;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so the registered pins track the FSM without lag.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
        full_d = (count_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_tx        = tx_q;
    assign o_busy      = busy_q;
    assign o_fifo_full = full_q;
    assign o_overflow  = ovf_q;

endmodule
